// File: rtl/capture_pkg.sv
// Shared state encoding and default widths for the capture engine.
package capture_pkg;

  localparam int unsigned DEFAULT_ADDR_WIDTH = 16;
  localparam int unsigned DEFAULT_DATA_WIDTH = 32;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_DONE    = 2'd3
  } state_e;

endpackage

// File: rtl/capture_engine_if.sv
// Sampler FIFO read port and sample RAM write port seen by the capture engine.
interface capture_engine_if #(
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned DATA_WIDTH = 32
);
  logic                  fifo_empty;
  logic                  fifo_read_enable;
  logic [DATA_WIDTH-1:0] fifo_data;
  logic [ADDR_WIDTH-1:0] ram_address;
  logic [DATA_WIDTH-1:0] ram_data;
  logic                  ram_wren;

  modport master (
    input  fifo_empty,
    input  fifo_data,
    output fifo_read_enable,
    output ram_address,
    output ram_data,
    output ram_wren
  );

  modport slave (
    output fifo_empty,
    output fifo_data,
    input  fifo_read_enable,
    input  ram_address,
    input  ram_data,
    input  ram_wren
  );
endinterface

// File: rtl/capture_trigger_match.sv
// Combinational masked comparator: hit when every masked bit of data equals value.
module capture_trigger_match #(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0] data,
  input  logic [DATA_WIDTH-1:0] mask,
  input  logic [DATA_WIDTH-1:0] value,
  output logic                  hit
);
  assign hit = ((data ^ value) & mask) == '0;
endmodule

// File: rtl/capture_engine.sv
// Drains the sampler FIFO until a masked trigger, then streams words into sample RAM.
// Define CAPTURE_CHANGE_ONLY_EN to store only post-trigger words that differ from the last one.
module capture_engine
  import capture_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic                  abort,
  input  logic [DATA_WIDTH-1:0] trigger_mask,
  input  logic [DATA_WIDTH-1:0] trigger_value,
  input  logic [ADDR_WIDTH-1:0] length,
  output logic                  busy,
  output logic                  triggered,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] sample_count,
  capture_engine_if.master      bus
);

  localparam logic [ADDR_WIDTH:0]   RemOne   = (ADDR_WIDTH+1)'(1);
  localparam logic [ADDR_WIDTH:0]   RemFull  = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH-1:0] CountOne = ADDR_WIDTH'(1);

  state_e                state_q;
  logic [ADDR_WIDTH:0]   remaining_q;
  logic                  rd_pending_q;
  logic [DATA_WIDTH-1:0] mask_q;
  logic [DATA_WIDTH-1:0] value_q;
  logic                  ram_wren_q;
  logic [ADDR_WIDTH-1:0] ram_address_q;
  logic [DATA_WIDTH-1:0] ram_data_q;
  logic                  triggered_q;
  logic                  done_q;
  logic [ADDR_WIDTH-1:0] sample_count_q;

  logic active;
  logic rd_en;
  logic trigger_hit;
  logic keep_word;

  capture_trigger_match #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_trigger_match (
    .data  (bus.fifo_data),
    .mask  (mask_q),
    .value (value_q),
    .hit   (trigger_hit)
  );

`ifdef CAPTURE_CHANGE_ONLY_EN
  // ram_data_q always holds the last word written, including the trigger word.
  assign keep_word = bus.fifo_data != ram_data_q;
`else
  assign keep_word = 1'b1;
`endif

  assign active = (state_q == ST_ARMED) || (state_q == ST_CAPTURE);
  // Words still owed minus the one already in flight bounds further reads.
  assign rd_en  = active && !bus.fifo_empty && !abort &&
                  ((state_q == ST_ARMED) ||
                   (remaining_q > {{ADDR_WIDTH{1'b0}}, rd_pending_q}));

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q        <= ST_IDLE;
      remaining_q    <= '0;
      rd_pending_q   <= 1'b0;
      mask_q         <= '0;
      value_q        <= '0;
      ram_wren_q     <= 1'b0;
      ram_address_q  <= '0;
      ram_data_q     <= '0;
      triggered_q    <= 1'b0;
      done_q         <= 1'b0;
      sample_count_q <= '0;
    end else begin
      ram_wren_q   <= 1'b0;
      rd_pending_q <= rd_en;
      if (abort) begin
        state_q <= ST_IDLE;
        done_q  <= 1'b0;
      end else begin
        case (state_q)
          ST_IDLE, ST_DONE: begin
            if (start) begin
              state_q        <= ST_ARMED;
              triggered_q    <= 1'b0;
              done_q         <= 1'b0;
              sample_count_q <= '0;
              remaining_q    <= (length == '0) ? RemFull : {1'b0, length};
              mask_q         <= trigger_mask;
              value_q        <= trigger_value;
            end
          end
          ST_ARMED: begin
            if (rd_pending_q && trigger_hit) begin
              ram_wren_q     <= 1'b1;
              ram_address_q  <= '0;
              ram_data_q     <= bus.fifo_data;
              triggered_q    <= 1'b1;
              sample_count_q <= CountOne;
              remaining_q    <= remaining_q - RemOne;
              if (remaining_q == RemOne) begin
                state_q <= ST_DONE;
                done_q  <= 1'b1;
              end else begin
                state_q <= ST_CAPTURE;
              end
            end
          end
          ST_CAPTURE: begin
            if (rd_pending_q && keep_word) begin
              ram_wren_q     <= 1'b1;
              ram_address_q  <= sample_count_q;
              ram_data_q     <= bus.fifo_data;
              sample_count_q <= sample_count_q + CountOne;
              remaining_q    <= remaining_q - RemOne;
              if (remaining_q == RemOne) begin
                state_q <= ST_DONE;
                done_q  <= 1'b1;
              end
            end
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  assign bus.fifo_read_enable = rd_en;
  assign bus.ram_wren         = ram_wren_q;
  assign bus.ram_address      = ram_address_q;
  assign bus.ram_data         = ram_data_q;
  assign busy                 = active;
  assign triggered            = triggered_q;
  assign done                 = done_q;
  assign sample_count         = sample_count_q;

endmodule

// File: tb/tb_capture_engine.sv
// Scoreboard bench for capture_engine built with a 4-bit address so a full wrap is short.
`timescale 1ns/1ps
module tb_capture_engine;

  localparam int unsigned AW = 4;
  localparam int unsigned DW = 32;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_t;

  logic          clock = 1'b0;
  logic          reset_n;
  logic          start;
  logic          abort;
  logic [DW-1:0] trigger_mask;
  logic [DW-1:0] trigger_value;
  logic [AW-1:0] length;
  logic          busy;
  logic          triggered;
  logic          done;
  logic [AW-1:0] sample_count;

  capture_engine_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  capture_engine #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW)
  ) dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .start         (start),
    .abort         (abort),
    .trigger_mask  (trigger_mask),
    .trigger_value (trigger_value),
    .length        (length),
    .busy          (busy),
    .triggered     (triggered),
    .done          (done),
    .sample_count  (sample_count),
    .bus           (bus)
  );

  always #12.5 clock = ~clock;

  // Non-showahead FIFO model: q appears the cycle after the read strobe.
  logic [DW-1:0] mem [64];
  int            wr_ptr = 0;
  int            rd_ptr = 0;
  logic          stall = 1'b0;

  assign bus.fifo_empty = stall || (wr_ptr == rd_ptr);

  always @(posedge clock) begin
    if (bus.fifo_read_enable) begin
      bus.fifo_data <= mem[rd_ptr % 64];
      rd_ptr        <= rd_ptr + 1;
    end
  end

  int  n_checks = 0;
  int  n_fail   = 0;
  int  wr_count = 0;
  wr_t exp_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  always @(negedge clock) begin
    if (reset_n === 1'b1 && bus.ram_wren === 1'b1) begin
      wr_t e;
      wr_count++;
      if (exp_q.size() == 0) begin
        check("unexpected_write_addr", 64'(bus.ram_address), 64'hFFFF_FFFF);
      end else begin
        e = exp_q.pop_front();
        check("ram_address", 64'(bus.ram_address), 64'(e.addr));
        check("ram_data", 64'(bus.ram_data), 64'(e.data));
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic fifo_push(input logic [DW-1:0] d);
    mem[wr_ptr % 64] = d;
    wr_ptr++;
  endtask

  task automatic fifo_flush();
    wr_ptr = rd_ptr;
  endtask

  task automatic expect_wr(input int a, input logic [DW-1:0] d);
    wr_t e;
    e.addr = AW'(a);
    e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic pulse_start(input logic [DW-1:0] m, input logic [DW-1:0] v,
                             input logic [AW-1:0] len);
    trigger_mask  = m;
    trigger_value = v;
    length        = len;
    start         = 1'b1;
    tick();
    start         = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    int n = 0;
    while (done !== 1'b1 && n < budget) begin
      tick();
      n++;
    end
    check(name, 64'(done), 64'd1);
    tick();
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_busy"}, 64'(busy), 64'd0);
    check({tag, "_triggered"}, 64'(triggered), 64'd0);
    check({tag, "_done"}, 64'(done), 64'd0);
    check({tag, "_count"}, 64'(sample_count), 64'd0);
    check({tag, "_wren"}, 64'(bus.ram_wren), 64'd0);
    check({tag, "_addr"}, 64'(bus.ram_address), 64'd0);
    check({tag, "_data"}, 64'(bus.ram_data), 64'd0);
    check({tag, "_rden"}, 64'(bus.fifo_read_enable), 64'd0);
  endtask

  initial begin
    int base;
    int n;
    reset_n       = 1'b0;
    start         = 1'b0;
    abort         = 1'b0;
    trigger_mask  = '0;
    trigger_value = '0;
    length        = '0;
    tick();
    tick();
    check_idle_outputs("reset");
    reset_n = 1'b1;
    tick();

    // Basic run: mask 0 triggers on the first word.
    fifo_push(32'h11); fifo_push(32'h22); fifo_push(32'h33);
    fifo_push(32'h44); fifo_push(32'h55);
    expect_wr(0, 32'h11); expect_wr(1, 32'h22); expect_wr(2, 32'h33); expect_wr(3, 32'h44);
    pulse_start(32'h0, 32'h0, 4'd4);
    wait_done("basic_done", 40);
    check("basic_count", 64'(sample_count), 64'd4);
    check("basic_triggered", 64'(triggered), 64'd1);
    check("basic_busy", 64'(busy), 64'd0);
    check("basic_fifo_left", 64'(wr_ptr - rd_ptr), 64'd1);
    check("basic_scoreboard_empty", 64'(exp_q.size()), 64'd0);
    fifo_flush();

    // Masked trigger skips the first word.
    fifo_push(32'h100); fifo_push(32'h2A5); fifo_push(32'h3A5); fifo_push(32'h4A5);
    expect_wr(0, 32'h2A5); expect_wr(1, 32'h3A5);
    pulse_start(32'h0000_00FF, 32'h0000_00A5, 4'd2);
    wait_done("trig_done", 40);
    check("trig_triggered", 64'(triggered), 64'd1);
    check("trig_count", 64'(sample_count), 64'd2);
    check("trig_fifo_left", 64'(wr_ptr - rd_ptr), 64'd1);
    check("trig_scoreboard_empty", 64'(exp_q.size()), 64'd0);
    fifo_flush();

    // Stall: FIFO empty for 10 cycles after the first word.
    fifo_push(32'hA1);
    expect_wr(0, 32'hA1); expect_wr(1, 32'hA2); expect_wr(2, 32'hA3);
    base = wr_count;
    pulse_start(32'h0, 32'h0, 4'd3);
    repeat (4) tick();
    check("stall_first_write", 64'(wr_count - base), 64'd1);
    repeat (10) tick();
    check("stall_busy", 64'(busy), 64'd1);
    check("stall_no_write", 64'(wr_count - base), 64'd1);
    check("stall_count_hold", 64'(sample_count), 64'd1);
    fifo_push(32'hA2); fifo_push(32'hA3); fifo_push(32'hA4);
    wait_done("stall_done", 40);
    check("stall_writes", 64'(wr_count - base), 64'd3);
    check("stall_fifo_left", 64'(wr_ptr - rd_ptr), 64'd1);
    fifo_flush();

    // Abort with simultaneous start after two writes.
    for (int i = 0; i < 8; i++) fifo_push(32'hB0 + 32'(i));
    expect_wr(0, 32'hB0); expect_wr(1, 32'hB1);
    pulse_start(32'h0, 32'h0, 4'd8);
    n = 0;
    while (!(bus.ram_wren === 1'b1 && sample_count == 4'd2) && n < 40) begin
      tick();
      n++;
    end
    check("abort_reached_two", 64'(sample_count), 64'd2);
    abort = 1'b1;
    start = 1'b1;
    tick();
    abort = 1'b0;
    start = 1'b0;
    check("abort_busy", 64'(busy), 64'd0);
    repeat (6) tick();
    check("abort_still_idle", 64'(busy), 64'd0);
    check("abort_done", 64'(done), 64'd0);
    check("abort_count", 64'(sample_count), 64'd2);
    check("abort_triggered", 64'(triggered), 64'd1);
    check("abort_scoreboard_empty", 64'(exp_q.size()), 64'd0);
    fifo_flush();

    // Full wrap: length 0 means 16 words with a 4-bit address.
    for (int i = 0; i < 20; i++) fifo_push(32'hC00 + 32'(i));
    for (int i = 0; i < 16; i++) expect_wr(i, 32'hC00 + 32'(i));
    base = wr_count;
    pulse_start(32'h0, 32'h0, 4'd0);
    wait_done("wrap_done", 80);
    check("wrap_writes", 64'(wr_count - base), 64'd16);
    check("wrap_count", 64'(sample_count), 64'd0);
    check("wrap_fifo_left", 64'(wr_ptr - rd_ptr), 64'd4);
    fifo_flush();

    // Reset mid-capture, then a normal run.
    fifo_push(32'hE0); fifo_push(32'hE1); fifo_push(32'hE2);
    expect_wr(0, 32'hE0); expect_wr(1, 32'hE1); expect_wr(2, 32'hE2);
    pulse_start(32'h0, 32'h0, 4'd8);
    repeat (8) tick();
    check("rst_pre_busy", 64'(busy), 64'd1);
    reset_n = 1'b0;
    tick();
    check_idle_outputs("midrst");
    reset_n = 1'b1;
    fifo_flush();
    tick();
    fifo_push(32'hD0); fifo_push(32'hD1);
    expect_wr(0, 32'hD0); expect_wr(1, 32'hD1);
    pulse_start(32'h0, 32'h0, 4'd2);
    wait_done("post_rst_done", 40);
    check("post_rst_count", 64'(sample_count), 64'd2);
    repeat (3) tick();
    check("final_scoreboard_empty", 64'(exp_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
